// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
//   Shared constants and types for the pipeline sequencer: stop/no-stop
//   levels, reset level, stall masks and the fetch-drain FSM state type.
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam logic STOP       = 1'b1;
  localparam logic NOSTOP     = 1'b0;
  localparam logic RST_ENABLE = 1'b0;

  // stall bit order: [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB [5]WB
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_if
//   Bundles the sequencer's pipeline-facing signals.
//   master : pipeline side (drives stall requests, branch info, fetch status)
//   slave  : pipe_ctrl (drives stall bus, flush, redirect, drop, perf counts)
// ---------------------------------------------------------------------------
interface pipe_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 32
);
  logic              stallreq_if;
  logic              stallreq_id;
  logic              stallreq_ex;
  logic              stallreq_mem;
  logic              branch_flag;
  logic [ADDR_W-1:0] branch_target;
  logic              if_busy;
  logic              fetch_done;
  logic [5:0]        stall;
  logic              flush;
  logic              new_pc_valid;
  logic [ADDR_W-1:0] new_pc;
  logic              drop_fetch;
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  redirect_cnt;

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    output branch_flag, branch_target, if_busy, fetch_done,
    input  stall, flush, new_pc_valid, new_pc, drop_fetch,
    input  stall_cycles, redirect_cnt
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    input  branch_flag, branch_target, if_busy, fetch_done,
    output stall, flush, new_pc_valid, new_pc, drop_fetch,
    output stall_cycles, redirect_cnt
  );
endinterface

// File: rtl/pipe_ctrl_perf_cnt.sv
// ---------------------------------------------------------------------------
// ctrl_perf_cnt
//   Saturating event counter: increments on i_inc, holds at all-ones.
//   clk   : clock
//   rst   : async reset, active-low
//   i_inc : count this cycle
//   o_cnt : current count
// ---------------------------------------------------------------------------
module ctrl_perf_cnt
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
//   Central sequencer for the 5-stage core. Merges stage stall requests into
//   the shared stall bus, issues EX-resolved redirects (flush + new PC),
//   discards a fetch that was in flight when a redirect hit, and keeps
//   saturating stall/redirect perf counters.
//   clk : core clock
//   rst : async reset, active-low
//   bus : pipe_ctrl_if.slave (stall requests, branch, fetch status in;
//         stall, flush, new_pc_valid, new_pc, drop_fetch, counters out)
// ---------------------------------------------------------------------------
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic              w_redirect;
  logic [5:0]        w_stall;
  logic [CNT_W-1:0]  w_stall_cycles;
  logic [CNT_W-1:0]  w_redirect_cnt;

  // A branch only redirects once its EX slot actually advances.
  assign w_redirect = bus.branch_flag & ~bus.stallreq_ex & ~bus.stallreq_mem;

  // Redirect sits between EX and ID priority: when it fires, mem/ex are
  // already clear, and IF/ID requests belong to squashed instructions.
  always_comb begin
    w_stall = STALL_NONE;
    if (bus.stallreq_mem) begin
      w_stall = STALL_MEM;
    end else if (bus.stallreq_ex) begin
      w_stall = STALL_EX;
    end else if (w_redirect) begin
      w_stall = STALL_NONE;
    end else if (bus.stallreq_id) begin
      w_stall = STALL_ID;
    end else if (bus.stallreq_if) begin
      w_stall = STALL_IF;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A fetch returning in the redirect cycle is killed by flush, so DRAIN is
  // only needed when it is still outstanding afterwards.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_redirect && bus.if_busy && !bus.fetch_done) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (bus.fetch_done) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.stall        = w_stall;
  assign bus.flush        = w_redirect;
  assign bus.new_pc_valid = w_redirect;
  assign bus.new_pc       = w_redirect ? bus.branch_target : '0;
  assign bus.drop_fetch   = (r_state == ST_DRAIN);

  ctrl_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (|w_stall),
    .o_cnt (w_stall_cycles)
  );

  ctrl_perf_cnt #(.CNT_W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_redirect),
    .o_cnt (w_redirect_cnt)
  );

  assign bus.stall_cycles = w_stall_cycles;
  assign bus.redirect_cnt = w_redirect_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl
//   Directed bench for pipe_ctrl. Counters are built 4 bits wide so that
//   saturation is reachable in a few cycles. Inputs change 1 time unit after
//   the rising edge; outputs are checked on the falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipe_ctrl;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  pipe_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  pipe_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic id, input logic ex, input logic mem, input logic ifr,
                       input logic br, input logic [31:0] tgt,
                       input logic busy, input logic done);
    bus.stallreq_id   = id;
    bus.stallreq_ex   = ex;
    bus.stallreq_mem  = mem;
    bus.stallreq_if   = ifr;
    bus.branch_flag   = br;
    bus.branch_target = tgt;
    bus.if_busy       = busy;
    bus.fetch_done    = done;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 32'h0, 0, 0);
    #2;
    check("rst_stall", 64'(bus.stall), 64'h0);
    check("rst_flush", 64'(bus.flush), 64'h0);
    check("rst_npv", 64'(bus.new_pc_valid), 64'h0);
    check("rst_new_pc", 64'(bus.new_pc), 64'h0);
    check("rst_drop", 64'(bus.drop_fetch), 64'h0);
    check("rst_sc", 64'(bus.stall_cycles), 64'h0);
    check("rst_rc", 64'(bus.redirect_cnt), 64'h0);
    next_cycle();
    rst = 1'b1;

    // Stall merge and priority (stall_cycles: 1..4)
    drive(1, 0, 0, 0, 0, 32'h0, 0, 0);
    @(negedge clk) check("stall_id", 64'(bus.stall), 64'h07);
    next_cycle();
    drive(1, 0, 1, 0, 0, 32'h0, 0, 0);
    @(negedge clk) check("stall_mem_over_id", 64'(bus.stall), 64'h1f);
    next_cycle();
    drive(0, 1, 0, 1, 0, 32'h0, 0, 0);
    @(negedge clk) check("stall_ex_over_if", 64'(bus.stall), 64'h0f);
    next_cycle();
    drive(0, 0, 0, 1, 0, 32'h0, 0, 0);
    @(negedge clk) check("stall_if", 64'(bus.stall), 64'h03);
    next_cycle();
    drive(0, 0, 0, 0, 0, 32'h0, 0, 0);
    @(negedge clk);
    check("stall_none", 64'(bus.stall), 64'h0);
    check("sc_after_4", 64'(bus.stall_cycles), 64'h4);
    next_cycle();

    // Plain redirect (redirect_cnt 1)
    drive(0, 0, 0, 0, 1, 32'h100, 0, 0);
    @(negedge clk);
    check("br_flush", 64'(bus.flush), 64'h1);
    check("br_npv", 64'(bus.new_pc_valid), 64'h1);
    check("br_new_pc", 64'(bus.new_pc), 64'h100);
    next_cycle();
    drive(0, 0, 0, 0, 0, 32'h0, 0, 0);
    @(negedge clk);
    check("br_flush_off", 64'(bus.flush), 64'h0);
    check("br_npv_off", 64'(bus.new_pc_valid), 64'h0);
    check("br_rc", 64'(bus.redirect_cnt), 64'h1);
    check("br_drop", 64'(bus.drop_fetch), 64'h0);
    next_cycle();

    // Branch held by MEM stall for 3 cycles (stall_cycles 5..7, redirect_cnt 2)
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 1, 32'h200, 0, 0);
      @(negedge clk);
      check("held_no_flush", 64'(bus.flush), 64'h0);
      check("held_stall", 64'(bus.stall), 64'h1f);
      next_cycle();
    end
    drive(0, 0, 0, 0, 1, 32'h200, 0, 0);
    @(negedge clk);
    check("held_fire_flush", 64'(bus.flush), 64'h1);
    check("held_fire_pc", 64'(bus.new_pc), 64'h200);
    check("held_fire_stall", 64'(bus.stall), 64'h0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 32'h0, 0, 0);
    @(negedge clk);
    check("held_rc", 64'(bus.redirect_cnt), 64'h2);
    check("held_sc", 64'(bus.stall_cycles), 64'h7);
    next_cycle();

    // Redirect with an outstanding fetch returning 3 cycles later (rc 3)
    drive(0, 0, 0, 0, 1, 32'h300, 1, 0);
    @(negedge clk) check("drain_c0_drop", 64'(bus.drop_fetch), 64'h0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 32'h0, 1, 0);
    @(negedge clk) check("drain_c1_drop", 64'(bus.drop_fetch), 64'h1);
    next_cycle();
    @(negedge clk) check("drain_c2_drop", 64'(bus.drop_fetch), 64'h1);
    next_cycle();
    drive(0, 0, 0, 0, 0, 32'h0, 1, 1);
    @(negedge clk) check("drain_c3_drop", 64'(bus.drop_fetch), 64'h1);
    next_cycle();
    drive(0, 0, 0, 0, 0, 32'h0, 0, 0);
    @(negedge clk) check("drain_c4_idle", 64'(bus.drop_fetch), 64'h0);
    next_cycle();

    // Same-cycle fetch_done: no drain (rc 4)
    drive(0, 0, 0, 0, 1, 32'h400, 1, 1);
    @(negedge clk) check("samecyc_drop0", 64'(bus.drop_fetch), 64'h0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 32'h0, 0, 0);
    @(negedge clk) check("samecyc_drop1", 64'(bus.drop_fetch), 64'h0);
    next_cycle();

    // Redirect while draining keeps DRAIN (rc 5, 6)
    drive(0, 0, 0, 0, 1, 32'h500, 1, 0);
    next_cycle();
    drive(0, 0, 0, 0, 1, 32'h600, 1, 0);
    @(negedge clk) check("redrain_drop_a", 64'(bus.drop_fetch), 64'h1);
    next_cycle();
    drive(0, 0, 0, 0, 0, 32'h0, 1, 0);
    @(negedge clk) check("redrain_drop_b", 64'(bus.drop_fetch), 64'h1);
    next_cycle();
    drive(0, 0, 0, 0, 0, 32'h0, 1, 1);
    next_cycle();
    drive(0, 0, 0, 0, 0, 32'h0, 0, 0);
    @(negedge clk) check("redrain_idle", 64'(bus.drop_fetch), 64'h0);
    next_cycle();

    // ID stall squashed by redirect (rc 7, sc stays 7)
    drive(1, 0, 0, 0, 1, 32'h700, 0, 0);
    @(negedge clk);
    check("idbr_stall", 64'(bus.stall), 64'h0);
    check("idbr_flush", 64'(bus.flush), 64'h1);
    next_cycle();
    drive(0, 0, 0, 0, 0, 32'h0, 0, 0);
    @(negedge clk);
    check("idbr_sc", 64'(bus.stall_cycles), 64'h7);
    check("idbr_rc", 64'(bus.redirect_cnt), 64'h7);
    next_cycle();

    // Async reset in the middle of DRAIN
    drive(0, 0, 0, 0, 1, 32'h800, 1, 0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 32'h0, 1, 0);
    @(negedge clk);
    check("prerst_drop", 64'(bus.drop_fetch), 64'h1);
    check("prerst_rc", 64'(bus.redirect_cnt), 64'h8);
    #1 rst = 1'b0;
    #1;
    check("arst_drop", 64'(bus.drop_fetch), 64'h0);
    check("arst_sc", 64'(bus.stall_cycles), 64'h0);
    check("arst_rc", 64'(bus.redirect_cnt), 64'h0);
    drive(0, 0, 0, 0, 0, 32'h0, 0, 0);
    next_cycle();
    rst = 1'b1;

    // Saturation: 16 stall cycles -> 15, then one more still 15
    drive(0, 0, 0, 1, 0, 32'h0, 0, 0);
    for (int i = 0; i < 16; i++) next_cycle();
    @(negedge clk) check("sc_sat", 64'(bus.stall_cycles), 64'hf);
    next_cycle();
    @(negedge clk) check("sc_sat_hold", 64'(bus.stall_cycles), 64'hf);
    next_cycle();
    drive(0, 0, 0, 0, 1, 32'h900, 0, 0);
    for (int i = 0; i < 16; i++) next_cycle();
    @(negedge clk) check("rc_sat", 64'(bus.redirect_cnt), 64'hf);
    next_cycle();
    drive(0, 0, 0, 0, 0, 32'h0, 0, 0);
    @(negedge clk);
    check("rc_sat_hold", 64'(bus.redirect_cnt), 64'hf);
    check("sc_sat_final", 64'(bus.stall_cycles), 64'hf);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
